// File: rtl/tremolo_modulator_pkg.sv
// ----------------------------------------------------------------------------
// tremolo_modulator_pkg
//   Shared constants and types for the tremolo modulator.
//   LFO_MAX_DEFAULT : full-scale LFO value (gain of 1000/1024)
//   GAIN_SHIFT      : right shift applied to sample * gain
//   sample_t        : default signed audio sample type
// ----------------------------------------------------------------------------
package tremolo_modulator_pkg;

   localparam int unsigned LFO_MAX_DEFAULT = 1000;
   localparam int unsigned GAIN_SHIFT      = 10;
   localparam int unsigned SAMPLE_W        = 16;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/tremolo_modulator_sat_mult_shift.sv
// ----------------------------------------------------------------------------
// sat_mult_shift
//   Combinational signed sample * unsigned gain, arithmetic shift right by
//   GAIN_SHIFT (floor toward minus infinity), saturated to DATA_W signed.
//   Ports:
//     sample : signed audio sample, DATA_W bits
//     gain   : unsigned gain, LFO_W bits
//     result : saturated, shifted product, DATA_W bits
// ----------------------------------------------------------------------------
module sat_mult_shift
   import tremolo_modulator_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LFO_W  = 11
) (
   input  logic signed [DATA_W-1:0] sample,
   input  logic        [LFO_W-1:0]  gain,
   output logic signed [DATA_W-1:0] result
);

   localparam int unsigned PROD_W = DATA_W + LFO_W + 1;

   logic signed [PROD_W-1:0] sample_ext;
   logic signed [PROD_W-1:0] gain_ext;
   logic signed [PROD_W-1:0] product;
   logic signed [PROD_W-1:0] shifted;
   logic signed [PROD_W-1:0] sat_max;
   logic signed [PROD_W-1:0] sat_min;

   always_comb begin
      sample_ext = {{(LFO_W + 1){sample[DATA_W-1]}}, sample};
      // Gain is unsigned: zero-extend so the signed multiply treats it as positive.
      gain_ext   = {{(DATA_W + 1){1'b0}}, gain};
      product    = sample_ext * gain_ext;
      shifted    = product >>> GAIN_SHIFT;

      sat_max                = '0;
      sat_max[DATA_W-2:0]    = '1;
      sat_min                = '1;
      sat_min[DATA_W-2:0]    = '0;

      if (shifted > sat_max) begin
         result = sat_max[DATA_W-1:0];
      end else if (shifted < sat_min) begin
         result = sat_min[DATA_W-1:0];
      end else begin
         result = shifted[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/tremolo_modulator.sv
// ----------------------------------------------------------------------------
// tremolo_modulator
//   Two-stage valid/ready pipeline applying an LFO-driven gain to audio.
//   S1 registers sample, clamped gain and bypass; S2 registers the result.
//   Ports:
//     CLK, RESET_N          : clock, asynchronous active-low reset
//     lfo_val, bypass       : modulation controls, sampled with in_sample
//     in_sample/valid/ready : input stream handshake
//     out_sample/valid/ready: output stream handshake
// ----------------------------------------------------------------------------
module tremolo_modulator
   import tremolo_modulator_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned LFO_W   = 11,
   parameter int unsigned LFO_MAX = LFO_MAX_DEFAULT
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic        [LFO_W-1:0]  lfo_val,
   input  logic                     bypass,
   input  logic signed [DATA_W-1:0] in_sample,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] out_sample,
   output logic                     out_valid,
   input  logic                     out_ready
);

   // Only used when lfo_val exceeds LFO_MAX, so truncation here is harmless.
   localparam logic [LFO_W-1:0] GAIN_MAX = LFO_W'(LFO_MAX);

   logic                     s1_valid_q,  s1_valid_d;
   logic signed [DATA_W-1:0] s1_sample_q, s1_sample_d;
   logic        [LFO_W-1:0]  s1_gain_q,   s1_gain_d;
   logic                     s1_bypass_q, s1_bypass_d;
   logic                     s2_valid_q,  s2_valid_d;
   logic signed [DATA_W-1:0] s2_sample_q, s2_sample_d;

   logic                     s2_adv;
   logic                     in_xfer;
   logic        [LFO_W-1:0]  gain_clamped;
   logic signed [DATA_W-1:0] mult_result;

   sat_mult_shift #(
      .DATA_W (DATA_W),
      .LFO_W  (LFO_W)
   ) u_sat_mult_shift (
      .sample (s1_sample_q),
      .gain   (s1_gain_q),
      .result (mult_result)
   );

   always_comb begin
      s2_adv       = !s2_valid_q || out_ready;
      // RESET_N gating keeps in_ready low while reset is held.
      in_ready     = RESET_N && (!s1_valid_q || s2_adv);
      in_xfer      = in_valid && in_ready;
      gain_clamped = (32'(lfo_val) > LFO_MAX) ? GAIN_MAX : lfo_val;

      s1_valid_d  = s1_valid_q;
      s1_sample_d = s1_sample_q;
      s1_gain_d   = s1_gain_q;
      s1_bypass_d = s1_bypass_q;
      s2_valid_d  = s2_valid_q;
      s2_sample_d = s2_sample_q;

      // S1 empties or refills whenever it may accept a new sample.
      if (in_ready) begin
         s1_valid_d = in_valid;
      end
      if (in_xfer) begin
         s1_sample_d = in_sample;
         s1_gain_d   = gain_clamped;
         s1_bypass_d = bypass;
      end

      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_sample_d = s1_bypass_q ? s1_sample_q : mult_result;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         s1_valid_q  <= 1'b0;
         s1_sample_q <= '0;
         s1_gain_q   <= '0;
         s1_bypass_q <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_sample_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sample_q <= s1_sample_d;
         s1_gain_q   <= s1_gain_d;
         s1_bypass_q <= s1_bypass_d;
         s2_valid_q  <= s2_valid_d;
         s2_sample_q <= s2_sample_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_sample = s2_sample_q;

endmodule

// File: tb/tb_tremolo_modulator.sv
module tb_tremolo_modulator;
   import tremolo_modulator_pkg::*;

   localparam int DATA_W  = 16;
   localparam int LFO_W   = 11;
   localparam int LFO_MAX = 1000;

   logic              CLK = 1'b0;
   logic              RESET_N = 1'b0;
   logic [LFO_W-1:0]  lfo_val = '0;
   logic              bypass = 1'b0;
   sample_t           in_sample = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   sample_t           out_sample;
   logic              out_valid;
   logic              out_ready = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int n_out    = 0;
   int exp_q[$];
   bit hold_prev = 1'b0;
   int held_val  = 0;

   tremolo_modulator #(
      .DATA_W  (DATA_W),
      .LFO_W   (LFO_W),
      .LFO_MAX (LFO_MAX)
   ) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .lfo_val    (lfo_val),
      .bypass     (bypass),
      .in_sample  (in_sample),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_sample (out_sample),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference: gain clamp, exact floor(sample*g/1024), saturate, or pass-through.
   function automatic int ref_result(int smp, int lfo, bit byp);
      longint g, p, r;
      if (byp) return smp;
      g = (lfo > LFO_MAX) ? LFO_MAX : lfo;
      p = longint'(smp) * g;
      if (p >= 0) r = p / 1024;
      else        r = -((-p + 1023) / 1024);
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      return int'(r);
   endfunction

   // One clock cycle of scoreboarded traffic; inputs already driven.
   task automatic step(input string tag, output bit accepted);
      accepted = 1'b0;
      @(negedge CLK);
      // Capacity-2 buffer: room unless two items are held and nothing leaves.
      check({tag, "_in_ready"}, in_ready, (exp_q.size() < 2 || out_ready) ? 1 : 0);
      if (hold_prev) begin
         check({tag, "_hold_valid"}, out_valid, 1);
         check({tag, "_hold_data"}, out_sample, held_val);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) check({tag, "_spurious_out"}, out_valid, 0);
         else begin
            check({tag, "_data"}, out_sample, exp_q.pop_front());
            n_out++;
         end
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(ref_result(int'(in_sample), int'(lfo_val), bypass));
         accepted = 1'b1;
      end
      hold_prev = out_valid && !out_ready;
      held_val  = int'(out_sample);
      @(posedge CLK);
      #1;
   endtask

   // Single isolated transfer with latency measurement; controls change after acceptance.
   task automatic send_one(input string tag, input int smp, input int lfo, input bit byp,
                           input int exp);
      int lat;
      int val;
      in_sample = sample_t'(smp);
      lfo_val   = LFO_W'(lfo);
      bypass    = byp;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge CLK);
      check({tag, "_accept"}, in_ready, 1);
      @(posedge CLK);
      #1;
      in_valid  = 1'b0;
      in_sample = sample_t'($urandom);
      lfo_val   = LFO_W'($urandom);
      bypass    = ~byp;
      lat = 0;
      val = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge CLK);
         if (out_valid && lat == 0) begin
            lat = i;
            val = int'(out_sample);
         end
      end
      check({tag, "_latency"}, lat, 2);
      check({tag, "_value"}, val, exp);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      bit acc;
      int sent;
      int start_out;
      int seen;

      // Reset state
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_sample", out_sample, 0);
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      #1;
      check("rst_release_in_ready", in_ready, 1);

      // Directed values
      send_one("pos_full",  16384, 1000, 1'b0, 16000);
      send_one("neg_full", -16384, 1000, 1'b0, -16000);
      send_one("floor",        -1,    1, 1'b0, -1);
      send_one("zero_gain", 12345,    0, 1'b0, 0);
      send_one("clamp",     16384, 2047, 1'b0, 16000);
      send_one("bypass",   -32768,    0, 1'b1, -32768);
      send_one("min_full", -32768, 1000, 1'b0, -32000);
      send_one("max_full",  32767, 1000, 1'b0, 31999);
      send_one("clamp_neg", -20000, 1500, 1'b0, ref_result(-20000, 1500, 1'b0));

      // Back-pressure stream: 8 samples, out_ready low on cycles 3..7
      sent = 0;
      start_out = n_out;
      for (int cyc = 0; cyc < 60 && (sent < 8 || exp_q.size() != 0); cyc++) begin
         in_valid  = (sent < 8);
         in_sample = sample_t'($urandom);
         lfo_val   = LFO_W'($urandom_range(0, 1100));
         bypass    = ($urandom_range(0, 7) == 0);
         out_ready = !(cyc >= 3 && cyc <= 7);
         #1;
         if (cyc == 6) check("bp_in_ready_low", in_ready, 0);
         step("bp", acc);
         if (acc) sent++;
      end
      check("bp_sent", sent, 8);
      check("bp_delivered", n_out - start_out, 8);

      // Randomized traffic
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 5))
            0:       in_sample = 16'sh8000;
            1:       in_sample = 16'sh7fff;
            default: in_sample = sample_t'($urandom);
         endcase
         lfo_val   = LFO_W'($urandom);
         bypass    = ($urandom_range(0, 9) == 0);
         out_ready = ($urandom_range(0, 9) < 6);
         step("rnd", acc);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 10 && exp_q.size() != 0; cyc++) step("drain", acc);
      check("drain_empty", exp_q.size(), 0);

      // Reset with both stages full
      in_valid  = 1'b1;
      out_ready = 1'b0;
      step("fill", acc);
      in_sample = 16'sh1234;
      step("fill", acc);
      in_valid = 1'b0;
      step("fill", acc);
      check("full_out_valid", out_valid, 1);
      check("full_in_ready", in_ready, 0);
      #2;
      RESET_N = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_in_ready", in_ready, 0);
      check("async_rst_out_sample", out_sample, 0);
      exp_q.delete();
      hold_prev = 1'b0;
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready, 1);
      out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (out_valid) seen++;
      end
      check("post_rst_no_stale", seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1);
   end

endmodule
